// File: rtl/sega_joy_scanner.sv
// ---------------------------------------------------------------------------
// sega_joy_scanner
//
// Scans NPORTS Sega DB9 joypad ports in parallel. One select line (pin 7) is
// shared by every port. A scan runs SCAN_LEN steps of TICK_DIV clocks each.
// A short burst of select pulses at the start of each scan reads the pads.
// The rest of each scan holds select high, so 6-button pads time out and
// return to their power-on state before the next burst.
//
// Capture points (the pins are those seen during the previous step):
//   enter k=2 : U,D,L,R,B,C          (select was high)
//   enter k=3 : MD detect, A,Start   (select was low)
//   enter k=5 : 6-button detect      (select was low, third pulse)
//   enter k=6 : Z,Y,X,Mode           (select was high after third pulse)
//   enter k=7 : done_o pulse
//
// Build option:
//   SEGA_JOY_SIX_BUTTON_EN - when defined, the third select pulse and the
//   6-button capture are enabled. When undefined, select stays high for
//   k=4..6, M/X/Y/Z read 0 and type_o never reports 11.
//
// Ports:
//   clk_i    in  1          system clock (the only clock)
//   res_n_i  in  1          asynchronous active-low reset
//   joy_i    in  6*NPORTS   per port {p9,p6,right,left,down,up}, active-low
//   sel_o    out 1          shared select, pin 7 of every port
//   joy_o    out 12*NPORTS  per port {M,X,Y,Z,S,A,C,B,R,L,D,U}, 1 = pressed
//   type_o   out 2*NPORTS   per port 00 none, 01 2-button, 10 MD3, 11 MD6
//   done_o   out 1          one-clock pulse when a scan's captures are done
// ---------------------------------------------------------------------------
module sega_joy_scanner #(
  parameter int NPORTS   = 2,
  parameter int TICK_DIV = 1024,
  parameter int SCAN_LEN = 256
) (
  input  logic                 clk_i,
  input  logic                 res_n_i,
  input  logic [6*NPORTS-1:0]  joy_i,
  output logic                 sel_o,
  output logic [12*NPORTS-1:0] joy_o,
  output logic [2*NPORTS-1:0]  type_o,
  output logic                 done_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int K_W   = (SCAN_LEN > 2) ? $clog2(SCAN_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SCAN_LEN - 1);

  localparam logic [K_W-1:0] K_0 = K_W'(0);
  localparam logic [K_W-1:0] K_2 = K_W'(2);
  localparam logic [K_W-1:0] K_3 = K_W'(3);
  localparam logic [K_W-1:0] K_7 = K_W'(7);
`ifdef SEGA_JOY_SIX_BUTTON_EN
  localparam logic [K_W-1:0] K_4 = K_W'(4);
  localparam logic [K_W-1:0] K_5 = K_W'(5);
  localparam logic [K_W-1:0] K_6 = K_W'(6);
`endif

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_TWO  = 2'b01;
  localparam logic [1:0] TYPE_MD3  = 2'b10;
`ifdef SEGA_JOY_SIX_BUTTON_EN
  localparam logic [1:0] TYPE_MD6  = 2'b11;
`endif

  // -------------------------------------------------------------------------
  // Input synchroniser. It resets to all-ones, which reads as "nothing
  // pressed" until real pin values arrive.
  // -------------------------------------------------------------------------
  logic [6*NPORTS-1:0] sync1_q;
  logic [6*NPORTS-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= joy_i;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Step divider. The strobe fires when the divider sits at TICK_DIV-1. After
  // reset the first strobe therefore lands exactly TICK_DIV clocks later.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             step_stb;

  assign step_stb = (div_q == DIV_LAST);
  assign div_d    = step_stb ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scan sequencer: the step index k is the state.
  // -------------------------------------------------------------------------
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] k_d;

  // State register
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      k_q <= K_0;
    end else begin
      k_q <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    k_d = k_q;
    if (step_stb) begin
      if (k_q == K_LAST) begin
        k_d = K_0;
      end else begin
        k_d = k_q + K_W'(1);
      end
    end
  end

  // Output decode. The outputs are keyed on k_d, so the captures happen on
  // the strobe edge. The pins they read are still the ones driven during the
  // previous step, because the new select value only appears after this edge.
  logic sel_d;
  logic done_d;
  logic cap_base;
  logic cap_md;
`ifdef SEGA_JOY_SIX_BUTTON_EN
  logic cap_six;
  logic cap_ext;
`endif

  always_comb begin
    sel_d = 1'b1;
    if ((k_d == K_0) || (k_d == K_2)) begin
      sel_d = 1'b0;
    end
`ifdef SEGA_JOY_SIX_BUTTON_EN
    if ((k_d == K_4) || (k_d == K_6)) begin
      sel_d = 1'b0;
    end
    cap_six = step_stb && (k_d == K_5);
    cap_ext = step_stb && (k_d == K_6);
`endif
    cap_base = step_stb && (k_d == K_2);
    cap_md   = step_stb && (k_d == K_3);
    done_d   = step_stb && (k_d == K_7);
  end

  // The select and done outputs are registered so the pads never see a glitch.
  logic sel_q;
  logic done_q;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sel_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      done_q <= done_d;
    end
  end

  assign sel_o  = sel_q;
  assign done_o = done_q;

  // -------------------------------------------------------------------------
  // Per-port capture. Each port keeps its own button, type and detect state.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    logic [5:0]  pin_n;   // {p9,p6,right,left,down,up}, active-low
    logic [11:0] btn_q;
    logic [11:0] btn_d;
    logic [1:0]  type_q;
    logic [1:0]  type_d;
`ifdef SEGA_JOY_SIX_BUTTON_EN
    logic        md_q;
    logic        md_d;
    logic        six_q;
    logic        six_d;
`endif

    assign pin_n = sync2_q[6*gi +: 6];

    always_comb begin
      btn_d  = btn_q;
      type_d = type_q;
`ifdef SEGA_JOY_SIX_BUTTON_EN
      md_d   = md_q;
      six_d  = six_q;
`endif
      // With select high the pin order {p9,p6,R,L,D,U} lines up directly
      // with the button order {C,B,R,L,D,U}.
      if (cap_base) begin
        btn_d[5:0] = ~pin_n;
`ifdef SEGA_JOY_SIX_BUTTON_EN
        six_d = 1'b0;
`endif
      end

      // A Mega Drive pad pulls left and right low while select is low.
      // A 2-button pad (or an empty port) cannot do that.
      if (cap_md) begin
        if (!pin_n[2] && !pin_n[3]) begin
          btn_d[7:6] = ~pin_n[5:4];   // {S,A} from {p9,p6}
          type_d     = TYPE_MD3;
`ifdef SEGA_JOY_SIX_BUTTON_EN
          md_d       = 1'b1;
`endif
        end else begin
          btn_d[7:6] = 2'b00;
          type_d     = TYPE_TWO;
`ifdef SEGA_JOY_SIX_BUTTON_EN
          md_d       = 1'b0;
`endif
        end
      end

`ifdef SEGA_JOY_SIX_BUTTON_EN
      // On the third low select pulse, a 6-button pad drives all four
      // directions low.
      if (cap_six && md_q && (pin_n[3:0] == 4'b0000)) begin
        six_d  = 1'b1;
        type_d = TYPE_MD6;
      end

      // On the next high phase the directions carry {Mode,X,Y,Z}.
      // Those map onto joy bits [11:8] in the same order.
      if (cap_ext) begin
        btn_d[11:8] = six_q ? ~pin_n[3:0] : 4'b0000;
      end
`endif
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
        btn_q  <= '0;
        type_q <= TYPE_NONE;
`ifdef SEGA_JOY_SIX_BUTTON_EN
        md_q   <= 1'b0;
        six_q  <= 1'b0;
`endif
      end else begin
        btn_q  <= btn_d;
        type_q <= type_d;
`ifdef SEGA_JOY_SIX_BUTTON_EN
        md_q   <= md_d;
        six_q  <= six_d;
`endif
      end
    end

    assign joy_o[12*gi +: 12] = btn_q;
    assign type_o[2*gi +: 2]  = type_q;
  end

endmodule

// File: tb/tb_sega_joy_scanner.sv
// ---------------------------------------------------------------------------
// Testbench for sega_joy_scanner.
//
// Behavioural pad models drive the pins. Each pad reacts only to the select
// history, the way real hardware does: a 6-button pad counts the select
// pulses and times out when select stays high.
//
// Each time a scan's stimulus is set up, the expected per-port type and
// buttons are pushed into a queue. They come from the pad kind and the held
// buttons. A separate monitor pops and compares on every done_o pulse.
// ---------------------------------------------------------------------------
module tb_sega_joy_scanner;

  localparam int NP     = 2;
  localparam int TD     = 4;
  localparam int SL     = 16;
  localparam int NSCANS = 30;
  localparam int MID    = 6;
`ifdef SEGA_JOY_SIX_BUTTON_EN
  localparam bit SIX_EN = 1'b1;
`else
  localparam bit SIX_EN = 1'b0;
`endif

  // Pad kinds
  localparam int PAD_NONE = 0;
  localparam int PAD_SMS  = 1;
  localparam int PAD_MD3  = 2;
  localparam int PAD_MD6  = 3;

  logic            clk   = 1'b0;
  logic            res_n = 1'b0;
  logic [6*NP-1:0] joy_i;
  logic            sel;
  logic [12*NP-1:0] joy_o;
  logic [2*NP-1:0] type_o;
  logic            done;

  int checks = 0;
  int errors = 0;
  int scan_no = 0;

  int          kind [NP];
  logic [11:0] btn  [NP];

  // Shared pad view of the select line: count of low pulses since idle.
  int   lows     = 0;
  int   hi_run   = 0;
  logic sel_prev = 1'b1;

  typedef struct {
    logic [12*NP-1:0] joy;
    logic [2*NP-1:0]  typ;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  sega_joy_scanner #(
    .NPORTS  (NP),
    .TICK_DIV(TD),
    .SCAN_LEN(SL)
  ) dut (
    .clk_i  (clk),
    .res_n_i(res_n),
    .joy_i  (joy_i),
    .sel_o  (sel),
    .joy_o  (joy_o),
    .type_o (type_o),
    .done_o (done)
  );

  // ---------------- pad models ----------------
  // The pin outputs are active-low {p9,p6,right,left,down,up}.
  // The button vector b is laid out {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  function automatic logic [5:0] pad_pins(input int k, input logic [11:0] b,
                                          input logic s, input int n);
    logic [5:0] r;
    r = 6'h3F;
    if (k == PAD_SMS) begin
      r = ~b[5:0];
    end else if (k == PAD_MD3 || k == PAD_MD6) begin
      if (s) begin
        if (k == PAD_MD6 && n == 3) r = ~{b[5], b[4], b[11], b[10], b[9], b[8]};
        else                        r = ~b[5:0];
      end else begin
        if (k == PAD_MD6 && n == 3) r = {~b[7], ~b[6], 4'b0000};
        else                        r = {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
      end
    end
    return r;
  endfunction

  always_comb begin
    joy_i = '1;
    for (int p = 0; p < NP; p++) begin
      joy_i[6*p +: 6] = pad_pins(kind[p], btn[p], sel, lows);
    end
  end

  always @(negedge clk) begin
    sel_prev <= sel;
    if (sel_prev === 1'b1 && sel === 1'b0) lows <= lows + 1;
    if (sel === 1'b1) begin
      hi_run <= hi_run + 1;
      if (hi_run > 3*TD) lows <= 0;
    end else begin
      hi_run <= 0;
    end
  end

  // ---------------- reference model ----------------
  // Returns {type, joy} for one port from the pad kind and its held buttons.
  function automatic logic [13:0] model(input int k, input logic [11:0] b);
    logic [13:0] r;
    case (k)
      PAD_SMS: r = {2'b01, b & 12'h03F};
      PAD_MD3: r = {2'b10, b & 12'h0FF};
      PAD_MD6: r = SIX_EN ? {2'b11, b} : {2'b10, b & 12'h0FF};
      default: r = {2'b01, 12'h000};
    endcase
    return r;
  endfunction

  // A d-pad cannot press opposite directions at the same time.
  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[0] && b[1]) b[1] = 1'b0;
    if (b[2] && b[3]) b[3] = 1'b0;
    return b;
  endfunction

  task automatic push_expected();
    exp_t        e;
    logic [13:0] m;
    for (int p = 0; p < NP; p++) begin
      m = model(kind[p], btn[p]);
      e.joy[12*p +: 12] = m[11:0];
      e.typ[2*p +: 2]   = m[13:12];
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 3*SL*TD);
    check("done_arrives", {31'd0, done}, 32'd1);
  endtask

  task automatic mid_reset();
    int n;
    // The previous done marked entry to k=7. Step k=5 of the next scan is
    // entered (SL-7+5) steps later.
    repeat ((SL - 7 + 5) * TD) @(posedge clk);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check("mid_rst_sel",  {31'd0, sel}, 32'd1);
    check("mid_rst_joy",  32'(joy_o), 32'd0);
    check("mid_rst_type", 32'(type_o), 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (5*TD) @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_sel_k0", {31'd0, sel}, 32'd0);
    n = 1;
    while (sel !== 1'b1 && n < 4*TD) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rel_first_strobe", n, TD);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int p = 0; p < NP; p++) begin
      kind[p] = PAD_NONE;
      btn[p]  = '0;
    end
    repeat (5*TD) @(negedge clk);
    check("rst_sel",  {31'd0, sel}, 32'd1);
    check("rst_joy",  32'(joy_o), 32'd0);
    check("rst_type", 32'(type_o), 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    push_expected();   // first scan: both ports unplugged
    res_n = 1'b1;

    for (int i = 0; i < NSCANS; i++) begin
      wait_done();
      case (i)
        0: begin
          kind[0] = PAD_MD3; btn[0] = 12'h0C1;   // Start + A + Up
          kind[1] = PAD_MD6; btn[1] = 12'hC10;   // Mode + X + B
        end
        1: begin
          kind[0] = PAD_SMS; btn[0] = 12'h038;   // button 1 + button 2 + Right
        end
        2: begin
          kind[0] = PAD_MD6; btn[0] = 12'hFF5;   // everything but Down/Right
          kind[1] = PAD_NONE; btn[1] = 12'hFFF;
        end
        default: begin
          for (int p = 0; p < NP; p++) begin
            kind[p] = int'($urandom_range(0, 3));
            btn[p]  = rand_btn();
          end
        end
      endcase
      push_expected();
      if (i == MID) mid_reset();
    end

    wait_done();
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_n === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_expected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          for (int p = 0; p < NP; p++) begin
            check($sformatf("joy_p%0d", p),  32'(joy_o[12*p +: 12]), 32'(e.joy[12*p +: 12]));
            check($sformatf("type_p%0d", p), 32'(type_o[2*p +: 2]),  32'(e.typ[2*p +: 2]));
          end
          $display("scan %0d: type_o=%b joy_o=%h", scan_no, type_o, joy_o);
          scan_no++;
        end
      end
    end
  end

  // ---------------- select sequence and first-scan timing ----------------
  initial begin
    int   first_done;
    int   done_cnt;
    int   k;
    logic exp_sel;
    first_done = -1;
    done_cnt   = 0;
    @(posedge res_n);
    for (int e = 1; e <= SL*TD; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = e;
      end
      if (e % TD == 1) begin
        k = (e - 1) / TD;
        exp_sel = !((k == 0) || (k == 2) || (SIX_EN && ((k == 4) || (k == 6))));
        check($sformatf("sel_k%0d", k), {31'd0, sel}, {31'd0, exp_sel});
      end
    end
    check("first_done_clk", first_done, 7*TD);
    check("done_pulse_count", done_cnt, 1);
  end

endmodule
